// File: rtl/pmac_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate unit.
// Saturation helpers are only referenced when PMAC_SAT_EN is defined.
package pmac_pkg;

    localparam int PMAC_MAX_ACC_W = 64;

    typedef struct packed {
        logic valid;
        logic sgn;
        logic first;
        logic last;
    } stage_ctrl_t;

    function automatic logic [PMAC_MAX_ACC_W-1:0] sat_max(input logic sgn, input int w);
        logic [PMAC_MAX_ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < PMAC_MAX_ACC_W; i++) begin
            if (i < w - 1) begin
                r[i] = 1'b1;
            end else if ((i == w - 1) && !sgn) begin
                r[i] = 1'b1;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [PMAC_MAX_ACC_W-1:0] sat_min(input logic sgn, input int w);
        logic [PMAC_MAX_ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < PMAC_MAX_ACC_W; i++) begin
            if (sgn && (i == w - 1)) begin
                r[i] = 1'b1;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_pipe_reg.sv
// One stall-able pipeline register carrying a product and its beat control.
module mac_pipe_reg
    import pmac_pkg::*;
#(
    parameter int W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  stage_ctrl_t i_ctrl,
    input  logic [W-1:0] i_data,
    output stage_ctrl_t o_ctrl,
    output logic [W-1:0] o_data
);

    stage_ctrl_t  r_ctrl;
    logic [W-1:0] r_data;

    // Stage register: advances only when the whole pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
            r_data <= '0;
        end else if (i_en) begin
            r_ctrl <= i_ctrl;
            r_data <= i_data;
        end else begin
            r_ctrl <= r_ctrl;
            r_data <= r_data;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/pipelined_mac.sv
// Pipelined multiply-accumulate with first/last framing and valid/ready handshakes.
// Optional saturation and overflow flag enabled by defining PMAC_SAT_EN.
module pipelined_mac
    import pmac_pkg::*;
#(
    parameter int A_WIDTH     = 8,
    parameter int B_WIDTH     = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic                 in_signed,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);

    localparam int PW = A_WIDTH + B_WIDTH;

    logic                 w_adv;
    logic [PW-1:0]        w_prod_u;
    logic [PW-1:0]        w_prod_s;
    stage_ctrl_t          w_ctrl [0:PIPE_STAGES];
    logic [PW-1:0]        w_data [0:PIPE_STAGES];
    stage_ctrl_t          w_tail;
    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 w_ovf_next;

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_acc;
    logic                 r_out_ovf;

    // A full output register blocks the whole pipe until it is taken.
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv;

    assign w_prod_u = {{B_WIDTH{1'b0}}, in_a} * {{A_WIDTH{1'b0}}, in_b};
    assign w_prod_s = $signed({{B_WIDTH{in_a[A_WIDTH-1]}}, in_a})
                    * $signed({{A_WIDTH{in_b[B_WIDTH-1]}}, in_b});

    assign w_ctrl[0] = {in_valid, in_signed, in_first, in_last};
    assign w_data[0] = in_signed ? w_prod_s : w_prod_u;

    genvar g;
    generate
        for (g = 0; g < PIPE_STAGES; g++) begin : g_pipe
            mac_pipe_reg #(.W(PW)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_en   (w_adv),
                .i_ctrl (w_ctrl[g]),
                .i_data (w_data[g]),
                .o_ctrl (w_ctrl[g+1]),
                .o_data (w_data[g+1])
            );
        end
        if (ACC_WIDTH > PW) begin : g_ext
            assign w_ext = {{(ACC_WIDTH-PW){w_tail.sgn & w_data[PIPE_STAGES][PW-1]}},
                            w_data[PIPE_STAGES]};
        end else begin : g_noext
            assign w_ext = w_data[PIPE_STAGES];
        end
    endgenerate

    assign w_tail = w_ctrl[PIPE_STAGES];
    assign w_base = w_tail.first ? {ACC_WIDTH{1'b0}} : r_acc;

`ifdef PMAC_SAT_EN
    logic [ACC_WIDTH:0]          w_sum;
    logic                        w_ovf_now;
    logic [PMAC_MAX_ACC_W-1:0]   w_max;
    logic [PMAC_MAX_ACC_W-1:0]   w_min;

    // Saturating add: clamp towards the side the base value was on.
    always_comb begin
        w_sum     = {1'b0, w_base} + {1'b0, w_ext};
        w_max     = sat_max(w_tail.sgn, ACC_WIDTH);
        w_min     = sat_min(w_tail.sgn, ACC_WIDTH);
        w_ovf_now = 1'b0;
        if (w_tail.sgn) begin
            w_ovf_now = (w_base[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1])
                      && (w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
        end else begin
            w_ovf_now = w_sum[ACC_WIDTH];
        end
        if (w_ovf_now) begin
            w_acc_next = (w_tail.sgn && w_base[ACC_WIDTH-1]) ? w_min[ACC_WIDTH-1:0]
                                                             : w_max[ACC_WIDTH-1:0];
        end else begin
            w_acc_next = w_sum[ACC_WIDTH-1:0];
        end
        w_ovf_next = (w_tail.first ? 1'b0 : r_ovf) | w_ovf_now;
    end
`else
    // Wrap-around accumulation; no overflow tracking.
    always_comb begin
        w_acc_next = w_base + w_ext;
        w_ovf_next = 1'b0;
    end
`endif

    // Accumulator: consumes one valid beat per advancing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_adv && w_tail.valid) begin
            r_acc <= w_acc_next;
            r_ovf <= w_ovf_next;
        end else begin
            r_acc <= r_acc;
            r_ovf <= r_ovf;
        end
    end

    // Result register: loaded alongside the accumulator on a last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv) begin
            if (w_tail.valid && w_tail.last) begin
                r_out_valid <= 1'b1;
                r_out_acc   <= w_acc_next;
                r_out_ovf   <= w_ovf_next;
            end else begin
                r_out_valid <= 1'b0;
                r_out_acc   <= r_out_acc;
                r_out_ovf   <= r_out_ovf;
            end
        end else begin
            r_out_valid <= r_out_valid;
            r_out_acc   <= r_out_acc;
            r_out_ovf   <= r_out_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;

endmodule
